// File: rtl/wb_dcache_mem_bridge_pkg.sv
// Shared cache definitions: line/beat geometry and the
// state encoding of the dcache-to-memory bridge.
package cache_defs;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int DMEM_BEAT_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } type_dmem_bridge_states_e;

endpackage

// File: rtl/wb_dcache_mem_bridge.sv
// Splits one dcache line request into sequential beats on the
// data memory bus and reassembles read beats into a line.
module wb_dcache_mem_bridge
  import cache_defs::*;
#(
  parameter int LINE_WIDTH = DCACHE_LINE_WIDTH,
  parameter int BEAT_WIDTH = DMEM_BEAT_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  output logic                  mem2dcache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
  output logic                  mem_req_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BEAT_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i
);

  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int CW         = $clog2(BEATS);

  localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
    ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  type_dmem_bridge_states_e state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wr_q, wr_d;
  logic                  aborted_q, aborted_d;
  logic                  kill;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    line_d    = line_q;
    base_d    = base_q;
    wr_d      = wr_q;
    aborted_d = aborted_q;
    kill      = aborted_q | ~dcache2mem_req_i;

    mem2dcache_ack_o = 1'b0;
    mem_req_o        = 1'b0;
    mem_wr_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;

    unique case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        cnt_d     = '0;
        if (dcache2mem_req_i) begin
          state_d = XFER;
          wr_d    = dcache2mem_wr_i;
          base_d  = dcache2mem_addr_i & ~OFS_MASK;
          buf_d   = dcache2mem_data_i;
        end
      end
      XFER: begin
        mem_req_o   = 1'b1;
        mem_wr_o    = wr_q;
        mem_addr_o  = base_q + ADDR_WIDTH'(cnt_q)
                    * ADDR_WIDTH'(BEAT_BYTES);
        mem_wdata_o = buf_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH];
        if (!dcache2mem_req_i) aborted_d = 1'b1;
        if (mem_ack_i) begin
          if (!wr_q) begin
            buf_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata_i;
          end
          // a killed request never updates the visible line
          if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
            cnt_d   = '0;
            if (!wr_q) line_d = buf_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        mem2dcache_ack_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem2dcache_data_o = line_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      line_q    <= '0;
      base_q    <= '0;
      wr_q      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      line_q    <= line_d;
      base_q    <= base_d;
      wr_q      <= wr_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_wb_dcache_mem_bridge.sv
// Scoreboard bench for wb_dcache_mem_bridge: beat and line
// expectations are queued by stimulus and popped by a monitor.
module tb_wb_dcache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         dreq;
  logic         dwr;
  logic [31:0]  daddr;
  logic [127:0] dline;
  logic         mem2dcache_ack_o;
  logic [127:0] mem2dcache_data_o;
  logic         mem_req_o;
  logic         mem_wr_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_ack_i;
  logic [31:0]  mem_rdata_i = '0;
  logic         ack_resp = 1'b0;
  logic         spur_ack = 1'b0;

  assign mem_ack_i = ack_resp | spur_ack;

  always #5 clk = ~clk;

  wb_dcache_mem_bridge dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .dcache2mem_req_i  (dreq),
    .dcache2mem_wr_i   (dwr),
    .dcache2mem_addr_i (daddr),
    .dcache2mem_data_i (dline),
    .mem2dcache_ack_o  (mem2dcache_ack_o),
    .mem2dcache_data_o (mem2dcache_data_o),
    .mem_req_o         (mem_req_o),
    .mem_wr_o          (mem_wr_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_ack_i         (mem_ack_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    bit          chk_wd;
    bit          last;
  } beat_t;

  beat_t        bq[$];
  logic [127:0] lq[$];
  logic [127:0] last_line = '0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory model: ack after a per-beat latency
  logic [31:0] rd[4];
  int stall_beat = -1;
  int stall_len  = 1;
  int resp_beat  = 0;
  int wait_c     = 0;

  always begin
    @(posedge clk);
    #1;
    if (ack_resp) begin
      resp_beat++;
      ack_resp = 1'b0;
      wait_c   = 0;
    end
    if (mem_req_o) begin
      if (wait_c >= ((resp_beat == stall_beat) ? stall_len : 1)) begin
        ack_resp    = 1'b1;
        mem_rdata_i = rd[resp_beat & 3];
      end else begin
        wait_c++;
      end
    end else begin
      wait_c = 0;
    end
  end

  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_rst = 1'b1;
  logic        p_wr  = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wd   = '0;
  bit          ack_next = 1'b0;
  beat_t       mb;
  logic [127:0] ml;

  always @(negedge clk) begin
    if (!p_rst && p_req && !p_ack) begin
      chk("hold_req", 128'(mem_req_o), 128'(1'b1));
      chk("hold_addr", 128'(mem_addr_o), 128'(p_addr));
      chk("hold_wr", 128'(mem_wr_o), 128'(p_wr));
      chk("hold_wdata", 128'(mem_wdata_o), 128'(p_wd));
    end
    if (ack_next) begin
      chk("line_ack_latency", 128'(mem2dcache_ack_o), 128'(1'b1));
      ack_next = 1'b0;
    end
    if (mem2dcache_ack_o) begin
      if (lq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_line_ack: got ack=1 expected none");
      end else begin
        ml = lq.pop_front();
        chk("line_data", mem2dcache_data_o, ml);
      end
    end
    if (mem_req_o && mem_ack_i) begin
      if (bq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_beat: got addr %h expected none",
                 mem_addr_o);
      end else begin
        mb = bq.pop_front();
        chk("beat_addr", 128'(mem_addr_o), 128'(mb.addr));
        chk("beat_wr", 128'(mem_wr_o), 128'(mb.wr));
        if (mb.chk_wd)
          chk("beat_wdata", 128'(mem_wdata_o), 128'(mb.wd));
        ack_next = mb.last;
      end
    end
    p_req  = mem_req_o;
    p_ack  = mem_ack_i;
    p_rst  = rst_i;
    p_wr   = mem_wr_o;
    p_addr = mem_addr_o;
    p_wd   = mem_wdata_o;
  end

  task automatic wait_line_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem2dcache_ack_o && n < 100);
    chk("line_ack_seen", 128'(mem2dcache_ack_o), 128'(1'b1));
  endtask

  task automatic set_rd(input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3);
    rd[0] = r0;
    rd[1] = r1;
    rd[2] = r2;
    rd[3] = r3;
  endtask

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [127:0] d, input int sb,
                     input int sl, input bit scr);
    logic [31:0]  base;
    logic [127:0] exp_line;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++)
      bq.push_back('{addr: base + 32'(i * 4), wr: w,
                     wd: d[i*32 +: 32], chk_wd: w, last: (i == 3)});
    exp_line = w ? last_line : {rd[3], rd[2], rd[1], rd[0]};
    lq.push_back(exp_line);
    last_line  = exp_line;
    stall_beat = sb;
    stall_len  = sl;
    resp_beat  = 0;
    chk("idle_no_req", 128'(mem_req_o), 128'(1'b0));
    dreq  = 1'b1;
    dwr   = w;
    daddr = a;
    dline = d;
    @(posedge clk);
    #1;
    chk("beat0_latency", 128'(mem_req_o), 128'(1'b1));
    if (scr) begin
      daddr = ~a;
      dline = ~d;
      dwr   = ~w;
    end
    wait_line_ack();
    @(posedge clk);
    #1;
    dreq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b1;
    dreq  = 1'b0;
    dwr   = 1'b0;
    daddr = '0;
    dline = '0;
    set_rd('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 128'(mem_req_o), 128'(1'b0));
    chk("rst_wr", 128'(mem_wr_o), 128'(1'b0));
    chk("rst_addr", 128'(mem_addr_o), 128'(0));
    chk("rst_wdata", 128'(mem_wdata_o), 128'(0));
    chk("rst_ack", 128'(mem2dcache_ack_o), 128'(1'b0));
    chk("rst_data", mem2dcache_data_o, 128'(0));
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    set_rd(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    txn(1'b0, 32'h8000_1234, '0, -1, 1, 1'b0);

    txn(1'b1, 32'h0000_0100,
        {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000},
        -1, 1, 1'b0);
    set_rd(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    txn(1'b0, 32'h0000_0200, '0, -1, 1, 1'b0);

    set_rd(32'h5550, 32'h5551, 32'h5552, 32'h5553);
    txn(1'b0, 32'h0000_1000, '0, 2, 5, 1'b0);

    for (int i = 0; i < 2; i++)
      bq.push_back('{addr: 32'h3000 + 32'(i * 4), wr: 1'b0,
                     wd: '0, chk_wd: 1'b0, last: 1'b0});
    set_rd(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
    stall_beat = 1;
    stall_len  = 3;
    resp_beat  = 0;
    dreq  = 1'b1;
    dwr   = 1'b0;
    daddr = 32'h3008;
    dline = '0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(mem_req_o && mem_addr_o == 32'h3004) && n < 50);
    chk("kill_reach_beat1", 128'(mem_addr_o), 128'(32'h3004));
    dreq = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (mem_req_o && n < 50);
    chk("kill_back_idle", 128'(mem_req_o), 128'(1'b0));
    chk("kill_data_kept", mem2dcache_data_o, last_line);
    repeat (3) @(posedge clk);
    #1;
    chk("kill_stays_idle", 128'(mem_req_o), 128'(1'b0));
    set_rd(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    txn(1'b0, 32'h0000_3000, '0, -1, 1, 1'b0);

    for (int i = 0; i < 2; i++)
      bq.push_back('{addr: 32'h4000 + 32'(i * 4), wr: 1'b0,
                     wd: '0, chk_wd: 1'b0, last: 1'b0});
    set_rd(32'h7770, 32'h7771, 32'h7772, 32'h7773);
    stall_beat = 2;
    stall_len  = 4;
    resp_beat  = 0;
    dreq  = 1'b1;
    dwr   = 1'b0;
    daddr = 32'h4000;
    dline = {4{32'h1111_2222}};
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(mem_req_o && mem_addr_o == 32'h4008) && n < 50);
    chk("rst_reach_beat2", 128'(mem_addr_o), 128'(32'h4008));
    chk("rst_beat2_wdata", 128'(mem_wdata_o), 128'(32'h1111_2222));
    rst_i = 1'b1;
    dreq  = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("mid_rst_req", 128'(mem_req_o), 128'(1'b0));
    chk("mid_rst_wr", 128'(mem_wr_o), 128'(1'b0));
    chk("mid_rst_addr", 128'(mem_addr_o), 128'(0));
    chk("mid_rst_wdata", 128'(mem_wdata_o), 128'(0));
    chk("mid_rst_ack", 128'(mem2dcache_ack_o), 128'(1'b0));
    chk("mid_rst_data", mem2dcache_data_o, 128'(0));
    last_line = '0;
    @(posedge clk);
    #1;
    set_rd(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    txn(1'b0, 32'h8000_1234, '0, -1, 1, 1'b0);

    spur_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("spur_no_req", 128'(mem_req_o), 128'(1'b0));
      chk("spur_no_ack", 128'(mem2dcache_ack_o), 128'(1'b0));
    end
    spur_ack = 1'b0;
    chk("spur_data_kept", mem2dcache_data_o, last_line);
    txn(1'b1, 32'h0000_0508,
        {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000},
        -1, 1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("beat_q_drained", 128'(bq.size()), 128'(0));
    chk("line_q_drained", 128'(lq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
